// File: rtl/sim_bench.sv
// Self-checking performance-counter harness: LFSR events counted over a fixed window, then audited.
// Latency: sim_done rises WINDOW+3 refclk edges after reset release; outputs are registered.
// Backpressure: none; free-running once reset is released, terminal in DONE until reset.
module sim_bench #(
  parameter int unsigned WINDOW = 4096,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic        refclk,
  input  logic        rst,
  output logic        sim_success,
  output logic        sim_done,
  output logic [31:0] sim_report
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SNAP, S_CHECK, S_DONE} state_t;

  localparam logic [31:0] WIN32 = 32'(WINDOW);

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [3:0][31:0]  cnt_q, cnt_d;
  logic [31:0]       ncnt0_q, ncnt0_d;
  logic [31:0]       sh_cyc_q, sh_cyc_d;
  logic [3:0][31:0]  sh_cnt_q, sh_cnt_d;
  logic [31:0]       sh_ncnt0_q, sh_ncnt0_d;
  logic [3:0]        fail_mask_q, fail_mask_d;
  logic              done_q, done_d;
  logic              success_q, success_d;
  logic [31:0]       report_q, report_d;

  logic              in_run;
  logic              cnt0_inc;
  logic [3:0]        ev_inc;
  logic [3:0]        fm_calc;

  // Event strobes are the pre-shift LFSR bits, only live while measuring.
  assign in_run   = (state_q == S_RUN);
  assign cnt0_inc = in_run & lfsr_q[0];
  assign ev_inc   = {lfsr_q[3:1] & {3{in_run}}, cnt0_inc};

  // Audit of the frozen snapshot; only latched during CHECK.
  always_comb begin
    fm_calc    = 4'b0000;
    fm_calc[0] = (sh_cyc_q != WIN32);
    fm_calc[1] = ((sh_cnt_q[0] + sh_ncnt0_q) != WIN32);
    for (int i = 0; i < 4; i++) begin
      if (sh_cnt_q[i] > WIN32)  fm_calc[2] = 1'b1;
      if (sh_cnt_q[i] == 32'd0) fm_calc[3] = 1'b1;
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    ncnt0_d     = ncnt0_q;
    sh_cyc_d    = sh_cyc_q;
    sh_cnt_d    = sh_cnt_q;
    sh_ncnt0_d  = sh_ncnt0_q;
    fail_mask_d = fail_mask_q;

    case (state_q)
      S_IDLE: begin
        cyc_d   = '0;
        cnt_d   = '0;
        ncnt0_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cyc_d  = cyc_q + 32'd1;
        for (int i = 0; i < 4; i++) begin
          if (ev_inc[i]) cnt_d[i] = cnt_q[i] + 32'd1;
        end
        if (!lfsr_q[0]) ncnt0_d = ncnt0_q + 32'd1;
        // cyc_q counts completed RUN cycles, so this is the last one.
        if (cyc_q == WIN32 - 32'd1) state_d = S_SNAP;
      end
      S_SNAP: begin
        sh_cyc_d   = cyc_q;
        sh_cnt_d   = cnt_q;
        sh_ncnt0_d = ncnt0_q;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        fail_mask_d = fm_calc;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d    = (state_d == S_DONE);
    success_d = done_d && (fail_mask_d == 4'b0000);
    report_d  = done_d ? {8'hD0, 4'h0, fail_mask_d, sh_cyc_q[15:0]}
                       : {16'h5043, cyc_d[15:0]};
  end

  // State and output registers; reset returns every bit to its power-on value.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      cyc_q       <= '0;
      cnt_q       <= '0;
      ncnt0_q     <= '0;
      sh_cyc_q    <= '0;
      sh_cnt_q    <= '0;
      sh_ncnt0_q  <= '0;
      fail_mask_q <= '0;
      done_q      <= 1'b0;
      success_q   <= 1'b0;
      report_q    <= 32'h5043_0000;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      ncnt0_q     <= ncnt0_d;
      sh_cyc_q    <= sh_cyc_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_ncnt0_q  <= sh_ncnt0_d;
      fail_mask_q <= fail_mask_d;
      done_q      <= done_d;
      success_q   <= success_d;
      report_q    <= report_d;
    end
  end

  assign sim_done    = done_q;
  assign sim_success = success_q;
  assign sim_report  = report_q;

endmodule

// File: tb/tb_sim_bench.sv
// Bench for sim_bench: default-window and 16-cycle-window instances share clock and reset.
// Expected completions are queued at reset release and popped when sim_done rises.
// Covers reset hold, mid-run progress, abort/rerun, short window and an injected count fault.
module tb_sim_bench;

  typedef struct {
    int          lat;
    logic        succ;
    logic [31:0] rpt;
  } exp_t;

  logic        refclk;
  logic        rst;
  logic        sim_success, sim_done;
  logic [31:0] sim_report;
  logic        sim_success16, sim_done16;
  logic [31:0] sim_report16;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  sim_bench dut (
    .refclk      (refclk),
    .rst         (rst),
    .sim_success (sim_success),
    .sim_done    (sim_done),
    .sim_report  (sim_report)
  );

  sim_bench #(.WINDOW(16)) dut16 (
    .refclk      (refclk),
    .rst         (rst),
    .sim_success (sim_success16),
    .sim_done    (sim_done16),
    .sim_report  (sim_report16)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model of the audit for a given window, stepping the LFSR from the default seed.
  function automatic logic [3:0] model_mask(input int w);
    logic [15:0] l;
    int          c [4];
    int          nc0;
    logic [3:0]  fm;
    l   = 16'hACE1;
    nc0 = 0;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int k = 0; k < w; k++) begin
      for (int i = 0; i < 4; i++) if (l[i]) c[i]++;
      if (!l[0]) nc0++;
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
    fm    = 4'b0000;
    fm[1] = ((c[0] + nc0) != w);
    for (int i = 0; i < 4; i++) begin
      if (c[i] > w)  fm[2] = 1'b1;
      if (c[i] == 0) fm[3] = 1'b1;
    end
    return fm;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_report"},  sim_report,  32'h5043_0000);
    chk_eq({tag, "_done"},    {31'd0, sim_done},    32'd0);
    chk_eq({tag, "_success"}, {31'd0, sim_success}, 32'd0);
  endtask

  // Release reset at a falling edge and follow the run; edge 1 is the first rising edge with rst high.
  task automatic run(input int mid_at, input int abort_at, input int force_at);
    int          n16;
    bit          got;
    bit          armed;
    bit          forced;
    exp_t        e;
    logic [3:0]  fm16;
    n16    = 0;
    got    = 0;
    armed  = (force_at != 0);
    forced = 0;
    @(negedge refclk);
    rst = 1'b1;
    for (int n = 1; n <= 6000 && !got; n++) begin
      @(posedge refclk);
      #1;
      if (forced) begin
        release dut.cnt0_inc;
        forced = 0;
      end
      if (sim_done16 && n16 == 0) n16 = n;
      if (n == mid_at) begin
        chk_eq("mid_report", sim_report, 32'h5043_0064);
        chk_eq("mid_done", {31'd0, sim_done}, 32'd0);
      end
      if (armed && n >= force_at && dut.lfsr_q[0]) begin
        force dut.cnt0_inc = 1'b0;
        forced = 1;
        armed  = 0;
      end
      if (n == abort_at) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge refclk);
        return;
      end
      if (sim_done) begin
        got = 1;
        if (sb.size() == 0) begin
          chk_eq("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk_eq("done_latency", n, e.lat);
          chk_eq("success", {31'd0, sim_success}, {31'd0, e.succ});
          chk_eq("final_report", sim_report, e.rpt);
        end
      end
    end
    if (!got) chk_eq("done_timeout", 32'd0, 32'd1);

    fm16 = model_mask(16);
    chk_eq("w16_latency", n16, 19);
    chk_eq("w16_report_lo", {16'd0, sim_report16[15:0]}, 32'h0000_0010);
    chk_eq("w16_report_hi", {20'd0, sim_report16[31:20]}, 32'h0000_0D00);
    chk_eq("w16_report", sim_report16, {8'hD0, 4'h0, fm16, 16'h0010});
    chk_eq("w16_success", {31'd0, sim_success16}, {31'd0, (fm16 == 4'b0000)});

    // DONE is terminal: outputs must not move afterwards.
    if (got) begin
      repeat (5) @(posedge refclk);
      #1;
      chk_eq("sticky_done", {31'd0, sim_done}, 32'd1);
      chk_eq("sticky_report", sim_report, e.rpt);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge refclk);
    rst = 1'b0;
    repeat (cycles) @(negedge refclk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Long reset hold: outputs must stay at their reset values throughout.
    for (int k = 0; k < 10; k++) begin
      repeat (1000) @(posedge refclk);
      #1;
      check_reset_outputs("hold");
    end

    // Clean run with mid-run progress sample.
    sb.push_back('{lat: 4099, succ: 1'b1, rpt: 32'hD000_1000});
    run(101, 0, 0);

    // Abort in the middle of RUN, then a full rerun must reproduce the pass.
    apply_reset(10);
    run(0, 2001, 0);
    sb.push_back('{lat: 4099, succ: 1'b1, rpt: 32'hD000_1000});
    run(101, 0, 0);

    // One suppressed cnt0 increment must be caught by the cnt0+ncnt0 audit.
    apply_reset(10);
    sb.push_back('{lat: 4099, succ: 1'b0, rpt: 32'hD002_1000});
    run(0, 0, 500);

    chk_eq("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
